// File: rtl/mdu_iter.sv
// mdu_iter: iterative signed/unsigned MULT/DIV unit with private HI/LO for the EX stage.
// Optional MDU_EARLY_OUT_EN: a multiply finishes as soon as its remaining multiplier bits are zero.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a, r_m, r_p, r_l, r_hi, r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div, r_neg_q, r_neg_r, r_busy, r_done;

    logic               w_signed, w_is_div, w_start, w_rs_neg, w_rt_neg, w_dz, w_ge, w_last;
    logic [WIDTH-1:0]   w_rs_abs, w_rt_abs, w_m_nxt, w_sub, w_p_nxt, w_l_nxt, w_q, w_r;
    logic [WIDTH:0]     w_sum, w_rsh;
    logic [2*WIDTH-1:0] w_prod_raw, w_prod;

    assign w_signed = op == 3'd1 || op == 3'd3;
    assign w_is_div = op == 3'd3 || op == 3'd4;
    assign w_start  = op >= 3'd1 && op <= 3'd4;
    assign w_rs_neg = w_signed && rs_data[WIDTH-1];
    assign w_rt_neg = w_signed && rt_data[WIDTH-1];
    assign w_rs_abs = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_abs = w_rt_neg ? -rt_data : rt_data;
    assign w_dz     = w_is_div && rt_data == '0;

    // Multiply: {r_p, r_l} is the product shifting right; divide: r_p remainder, r_l dividend/quotient.
    assign w_sum   = {1'b0, r_p} + (r_m[0] ? {1'b0, r_a} : '0);
    assign w_m_nxt = r_m >> 1;
    assign w_rsh   = {r_p, r_l[WIDTH-1]};
    assign w_ge    = w_rsh >= {1'b0, r_a};
    assign w_sub   = w_rsh[WIDTH-1:0] - r_a;
    assign w_p_nxt = r_div ? (w_ge ? w_sub : w_rsh[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign w_l_nxt = r_div ? {r_l[WIDTH-2:0], w_ge} : {w_sum[0], r_l[WIDTH-1:1]};

`ifdef MDU_EARLY_OUT_EN
    // On an early exit r_cnt holds the number of shifts still owed to the product.
    assign w_last     = r_cnt == '0 || (!r_div && w_m_nxt == '0);
    assign w_prod_raw = {r_p, r_l} >> r_cnt;
`else
    assign w_last     = r_cnt == '0;
    assign w_prod_raw = {r_p, r_l};
`endif

    assign w_prod = r_neg_q ? -w_prod_raw : w_prod_raw;
    assign w_q    = r_neg_q ? -r_l : r_l;
    assign w_r    = r_neg_r ? -r_p : r_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_p     <= '0;
            r_l     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (op_valid && !cancel) begin
                    if (w_start) begin
                        r_div   <= w_is_div;
                        r_a     <= w_is_div ? w_rt_abs : w_rs_abs;
                        r_m     <= w_rt_abs;
                        r_p     <= '0;
                        // Divide by zero keeps the raw dividend so it lands in HI untouched.
                        r_l     <= w_is_div ? (w_dz ? rs_data : w_rs_abs) : '0;
                        r_neg_q <= (w_rs_neg ^ w_rt_neg) && !w_dz;
                        r_neg_r <= w_rs_neg && !w_dz;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else if (op == 3'd5) begin
                        r_hi <= rs_data;
                    end else if (op == 3'd6) begin
                        r_lo <= rs_data;
                    end
                end
                RUN: if (cancel) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_p <= w_p_nxt;
                    r_l <= w_l_nxt;
                    r_m <= w_m_nxt;
                    if (w_last) r_state <= FIX;
                    else r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!cancel) begin
                        r_hi   <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
                        r_lo   <= r_div ? w_q : w_prod[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign stall = r_busy && (op_valid || hilo_rd);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random MULT/DIV/MTHI/MTLO checks against an arithmetic reference model.
module tb_mdu_iter;
    logic        clk = 1'b0, rst = 1'b1, op_valid = 1'b0, cancel = 1'b0, hilo_rd = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          tests = 0, fails = 0;

    mdu_iter dut (.clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_data(rs_data),
                  .rt_data(rt_data), .cancel(cancel), .hilo_rd(hilo_rd), .busy(busy),
                  .stall(stall), .hi(hi), .lo(lo), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint p, sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = m_hi;
        l = m_lo;
        if (o == 3'd1) begin
            p = sa * sb;
            {h, l} = p;
        end else if (o == 3'd2) begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            {h, l} = p;
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (o == 3'd3) begin
            p = sa / sb;
            l = p[31:0];
            p = sa % sb;
            h = p[31:0];
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    function automatic int exp_busy(input logic [2:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        logic [31:0] mag;
        if (o == 3'd1 || o == 3'd2) begin
            mag = (o == 3'd1 && b[31]) ? -b : b;
            if (mag == 32'd0) return 2;
            for (int i = 31; i >= 0; i--) if (mag[i]) return i + 2;
        end
`endif
        return (o == 3'd0) ? 0 : 33;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n;
        @(negedge clk);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        if (o >= 3'd5) begin
            if (o == 3'd5) m_hi = a; else m_lo = a;
            chk("mt_busy", 64'(busy), 64'd0);
            chk("mt_done", 64'(done), 64'd0);
            chk("mt_hi", 64'(hi), 64'(m_hi));
            chk("mt_lo", 64'(lo), 64'(m_lo));
        end else begin
            model(o, a, b, eh, el);
            n = 0;
            while (busy && n < 100) begin
                n++;
                @(posedge clk); #1;
            end
            chk("busy_cycles", 64'(n), 64'(exp_busy(o, b)));
            chk("done_rise", 64'(done), 64'd1);
            chk("hi", 64'(hi), 64'(eh));
            chk("lo", 64'(lo), 64'(el));
            m_hi = eh;
            m_lo = el;
            @(posedge clk); #1;
            chk("done_fall", 64'(done), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a, b;
        logic [2:0]  o;
        logic        seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        hilo_rd = 1'b1; #1;
        chk("idle_stall", 64'(stall), 64'd0);
        hilo_rd = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFD, 32'd7);
        chk("mult_const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(3'd4, 32'd100, 32'd7);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd4, 32'd5, 32'd0);
        do_op(3'd3, 32'hFFFF_FFF0, 32'd0);
        do_op(3'd2, 32'd3, 32'd5);
        do_op(3'd2, 32'd9, 32'd0);
        do_op(3'd1, 32'd3, 32'hFFFF_FFFF);

        // hazard and cancel during a MULTU
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; rs_data = $urandom; rt_data = $urandom;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            hilo_rd = (c == 5);
            op_valid = (c == 6);
            op = (c == 6) ? 3'd4 : 3'd0;
            cancel = (c == 10);
            #1;
            if (c == 5) chk("stall_hilo_rd", 64'(stall), 64'd1);
            if (c == 6) chk("stall_op_valid", 64'(stall), 64'd1);
        end
        @(posedge clk); #1;
        cancel = 1'b0; op_valid = 1'b0; hilo_rd = 1'b0; op = 3'd0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hi", 64'(hi), 64'(m_hi));
        chk("cancel_lo", 64'(lo), 64'(m_lo));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= done | busy;
        end
        chk("cancel_quiet", 64'(seen), 64'd0);

        // reset in the middle of a DIV
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd5, 32'h1234, 32'd0);
        do_op(3'd6, 32'hABCD, 32'd0);

        // cancel beats op_valid in IDLE
        @(negedge clk);
        op_valid = 1'b1; cancel = 1'b1; op = 3'd5; rs_data = 32'hDEAD;
        @(posedge clk); #1;
        chk("cancel_mthi_hi", 64'(hi), 64'(m_hi));
        @(negedge clk);
        op = 3'd1;
        @(posedge clk); #1;
        op_valid = 1'b0; cancel = 1'b0; op = 3'd0;
        chk("cancel_mult_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(1, 6));
            a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            do_op(o, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
